axis_slave_fifo: RTL and testbench
==================================

Name: axis_slave_fifo

Overview:
- Parametrised AXI-Stream slave that accepts a byte-lane stream into an internal FIFO and presents it to a local consumer over a valid/ready interface.
- Adds buffering depth, TKEEP-aware null-beat filtering, packet boundary tracking and fill-level and packet statistics outputs.
- Sits at the receive edge of a stream datapath, in front of packet-processing logic.

Parameters:
- N, default 4: data width in bytes; tdata is 8*N bits, tkeep/tstrb are N bits.
- DEPTH, default 8: FIFO entries; power of two, at least 2.
- CNT_W, default 16: width of the packet counter.

Ports:
- aclk, in, 1: clock; all logic on the rising edge.
- aresetn, in, 1: synchronous active-low reset.
- tvalid, in, 1: AXI-Stream valid.
- tready, out, 1: AXI-Stream ready.
- tdata, in, 8*N: stream data.
- tstrb, in, N: position byte qualifier; ignored.
- tkeep, in, N: null-byte qualifier; bit i qualifies tdata[8i+7:8i].
- tlast, in, 1: packet boundary.
- out_valid, out, 1: FIFO head valid.
- out_ready, in, 1: consumer accepts head.
- out_data, out, 8*N: head data.
- out_keep, out, N: head keep.
- out_last, out, 1: head is the last beat of its packet.
- level, out, $clog2(DEPTH)+1: current occupancy.
- pkt_count, out, CNT_W: packets fully delivered to the consumer.

Behaviour:
- Reset: synchronous; aresetn low at a rising edge clears the pointers, level=0, pkt_count=0, out_valid=0 and tready=0. FIFO storage is not cleared. On the first edge with aresetn high, tready=1.
- Reset mid-operation: all buffered beats are discarded with no partial-packet recovery, and pkt_count returns to 0.
- tready is registered: tready = (next level < DEPTH). It never depends combinationally on tvalid or out_ready.
- Input handshake: a beat transfers when tvalid && tready at a rising edge.
- Write rule: a beat is written when the handshake occurs and (tkeep != 0 or tlast == 1).
- Null beats: a beat with tkeep == 0 and tlast == 0 is accepted and dropped, with no write and no level change.
- Null last beats: a beat with tkeep == 0 and tlast == 1 is stored so the packet boundary is preserved.
- Output handshake: a pop occurs on out_valid && out_ready. out_valid = (level != 0), and out_data/out_keep/out_last come from the head entry (registered memory read or direct array index, head pointer registered).
- Latency: a beat written at edge t is visible on out_valid after edge t; first-word latency is 1 cycle. There is no combinational input-to-output path.
- Simultaneous push and pop: level is unchanged and both pointers advance. This is legal when full only if tready was high, which cannot happen when full, so full blocks the push regardless of the pop.
- Next-level arithmetic: level_next = level + push - pop. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level distinguishes full from empty.
- Full (level == DEPTH): tready goes low on the edge that reaches full. It rises again on the edge after the first pop.
- Empty: out_valid = 0, and out_ready is ignored.
- pkt_count: increments by 1 on each pop with out_last = 1 and wraps from 2^CNT_W-1 to 0.
- Protocol: tvalid deassertion by the master without a handshake is tolerated; no data is captured.
- Unused inputs: tstrb plays no role in behaviour.

Test Plan:
- Reset with tvalid=1 and tdata=0xA5A5A5A5 → tready=0, level=0 and out_valid=0 throughout reset. On the first edge after release, tready=1 and nothing is stored.
- Single packet: beats 0x11111111, 0x22222222, 0x33333333 (last) with keep=0xF and out_ready=1 → identical order out, out_last only on 0x33333333, pkt_count=1, level returns to 0.
- Null filtering: a beat with keep=0x0 and last=0, then data 0x44 with keep=0x1 and last=1 → only one beat emerges (keep=0x1, last=1). A beat with keep=0x0 and last=1 emerges with keep=0x0 and out_last=1.
- Fill with DEPTH=8 and out_ready=0: push 8 beats → tready=0 after the 8th handshake and level=8. Then one pop → tready=1 on the following edge, and the 9th beat is accepted and appears after the original 8.
- Concurrent traffic: continuous tvalid and out_ready=1 for 20 beats with a random keep≠0 → level stays at or below 1, full throughput of one beat per cycle, data order preserved across pointer wrap.
- Mid-packet reset: 2 of 3 beats pushed, then aresetn low for 1 cycle → level=0, out_valid=0, pkt_count=0. The next full packet is delivered correctly.

Source files
------------

// File: rtl/axis_slave_fifo.sv
// ============================================================================
//  axis_slave_fifo
//  AXI-Stream slave: FIFO with null-beat filtering and packet statistics.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module axis_slave_fifo #(
   parameter int N     = 4,
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       tvalid,
   output logic                       tready,
   input  logic [8*N-1:0]             tdata,
   input  logic [N-1:0]               tstrb,
   input  logic [N-1:0]               tkeep,
   input  logic                       tlast,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [8*N-1:0]             out_data,
   output logic [N-1:0]               out_keep,
   output logic                       out_last,
   output logic [$clog2(DEPTH):0]     level,
   output logic [CNT_W-1:0]           pkt_count
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_LW = c_AW + 1;
   localparam int c_EW = 8*N + N + 1;
   localparam logic [c_LW-1:0] c_DEPTH = c_LW'(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("axis_slave_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [c_EW-1:0]  mem_q [DEPTH];
   logic [c_AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [c_AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [c_LW-1:0]  level_q, level_d;
   logic             tready_q, tready_d;
   logic [CNT_W-1:0] pkt_q, pkt_d;
   logic             push, pop;
   logic [c_EW-1:0]  head;
   logic             unused_tstrb;

   assign unused_tstrb = ^tstrb;

   // Beats with no valid bytes are swallowed unless they carry the packet boundary.
   assign push = tvalid && tready_q && ((tkeep != '0) || tlast);
   assign pop  = out_valid && out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      pkt_d    = pkt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + c_AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + c_AW'(1);
         if (out_last) begin
            pkt_d = pkt_q + CNT_W'(1);
         end
      end
      level_d  = level_q + c_LW'(push) - c_LW'(pop);
      tready_d = (level_d < c_DEPTH);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         tready_q <= 1'b0;
         pkt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         tready_q <= tready_d;
         pkt_q    <= pkt_d;
      end
   end

   // Storage is deliberately left out of reset; occupancy alone defines validity.
   always_ff @(posedge aclk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {tdata, tkeep, tlast};
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign out_data  = head[c_EW-1 -: 8*N];
   assign out_keep  = head[N:1];
   assign out_last  = head[0];
   assign out_valid = (level_q != '0);
   assign tready    = tready_q;
   assign level     = level_q;
   assign pkt_count = pkt_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_slave_fifo.sv
// Self-checking bench for axis_slave_fifo: fixed vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
`default_nettype none

module tb_axis_slave_fifo;

   localparam int N     = 4;
   localparam int DEPTH = 8;
   localparam int CNT_W = 4;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        tvalid = 1'b0;
   logic        tready;
   logic [31:0] tdata = '0;
   logic [3:0]  tstrb = '0;
   logic [3:0]  tkeep = '0;
   logic        tlast = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_last;
   logic [3:0]  level;
   logic [CNT_W-1:0] pkt_count;

   axis_slave_fifo #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .aclk(aclk), .aresetn(aresetn), .tvalid(tvalid), .tready(tready),
      .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_keep(out_keep), .out_last(out_last), .level(level),
      .pkt_count(pkt_count)
   );

   always #5 aclk = ~aclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: FIFO contents as a queue, ready/count tracked per the stream rules.
   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   beat_t q[$];
   logic  m_tready = 1'b0;
   int    m_pkt = 0;

   task automatic check_model(input string tag);
      chk({tag, "_tready"}, 32'(tready), 32'(m_tready));
      chk({tag, "_level"}, 32'(level), 32'(q.size()));
      chk({tag, "_ovalid"}, 32'(out_valid), 32'(q.size() != 0));
      chk({tag, "_pkt"}, 32'(pkt_count), 32'(m_pkt));
      if (q.size() != 0) begin
         chk({tag, "_data"}, out_data, q[0].d);
         chk({tag, "_keep"}, 32'(out_keep), 32'(q[0].k));
         chk({tag, "_last"}, 32'(out_last), 32'(q[0].l));
      end
   endtask

   task automatic step(input logic rn, input logic tv, input logic [31:0] d,
                       input logic [3:0] k, input logic l, input logic ordy,
                       input string tag);
      logic do_push, do_pop;
      aresetn   = rn;
      tvalid    = tv;
      tdata     = d;
      tkeep     = k;
      tlast     = l;
      tstrb     = 4'($urandom);
      out_ready = ordy;
      do_push = rn && tv && m_tready && ((k != 4'h0) || l);
      do_pop  = rn && (q.size() != 0) && ordy;
      @(posedge aclk);
      if (!rn) begin
         q.delete();
         m_tready = 1'b0;
         m_pkt    = 0;
      end else begin
         if (do_pop) begin
            if (q[0].l) m_pkt = (m_pkt + 1) % (1 << CNT_W);
            void'(q.pop_front());
         end
         if (do_push) q.push_back('{d: d, k: k, l: l});
         m_tready = (q.size() < DEPTH);
      end
      #1;
      check_model(tag);
   endtask

   typedef struct {
      logic        rn, tv;
      logic [31:0] d;
      logic [3:0]  k;
      logic        l, ordy;
      logic        e_trdy;
      int          e_lvl;
      logic        e_ov;
      logic [31:0] e_d;
      logic [3:0]  e_k;
      logic        e_l;
      int          e_pkt;
   } vec_t;

   vec_t tbl[14];

   initial begin
      //            rn    tv    data          keep  last  ordy   trdy lvl ov    e_data        e_k   e_l   pkt
      tbl[0]  = '{1'b0, 1'b1, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0,  1'b0, 0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
      tbl[1]  = '{1'b0, 1'b1, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0,  1'b0, 0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
      tbl[2]  = '{1'b1, 1'b1, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0,  1'b1, 0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
      tbl[3]  = '{1'b1, 1'b1, 32'h11111111, 4'hF, 1'b0, 1'b0,  1'b1, 1, 1'b1, 32'h11111111, 4'hF, 1'b0, 0};
      tbl[4]  = '{1'b1, 1'b1, 32'h22222222, 4'hF, 1'b0, 1'b0,  1'b1, 2, 1'b1, 32'h11111111, 4'hF, 1'b0, 0};
      tbl[5]  = '{1'b1, 1'b1, 32'h33333333, 4'hF, 1'b1, 1'b0,  1'b1, 3, 1'b1, 32'h11111111, 4'hF, 1'b0, 0};
      tbl[6]  = '{1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1,  1'b1, 2, 1'b1, 32'h22222222, 4'hF, 1'b0, 0};
      tbl[7]  = '{1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1,  1'b1, 1, 1'b1, 32'h33333333, 4'hF, 1'b1, 0};
      tbl[8]  = '{1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1,  1'b1, 0, 1'b0, 32'h0,        4'h0, 1'b0, 1};
      tbl[9]  = '{1'b1, 1'b1, 32'h0000DEAD, 4'h0, 1'b0, 1'b0,  1'b1, 0, 1'b0, 32'h0,        4'h0, 1'b0, 1};
      tbl[10] = '{1'b1, 1'b1, 32'h00000044, 4'h1, 1'b1, 1'b0,  1'b1, 1, 1'b1, 32'h00000044, 4'h1, 1'b1, 1};
      tbl[11] = '{1'b1, 1'b1, 32'h00000099, 4'h0, 1'b1, 1'b0,  1'b1, 2, 1'b1, 32'h00000044, 4'h1, 1'b1, 1};
      tbl[12] = '{1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1,  1'b1, 1, 1'b1, 32'h00000099, 4'h0, 1'b1, 2};
      tbl[13] = '{1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1,  1'b1, 0, 1'b0, 32'h0,        4'h0, 1'b0, 3};

      for (int i = 0; i < 14; i++) begin
         aresetn   = tbl[i].rn;
         tvalid    = tbl[i].tv;
         tdata     = tbl[i].d;
         tkeep     = tbl[i].k;
         tlast     = tbl[i].l;
         out_ready = tbl[i].ordy;
         @(posedge aclk);
         #1;
         chk($sformatf("tbl%0d_tready", i), 32'(tready), 32'(tbl[i].e_trdy));
         chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].e_lvl));
         chk($sformatf("tbl%0d_ovalid", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_pkt", i), 32'(pkt_count), 32'(tbl[i].e_pkt));
         if (tbl[i].e_ov) begin
            chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_d);
            chk($sformatf("tbl%0d_keep", i), 32'(out_keep), 32'(tbl[i].e_k));
            chk($sformatf("tbl%0d_last", i), 32'(out_last), 32'(tbl[i].e_l));
         end
      end

      // Fill to full with the consumer stalled, then release a single slot.
      step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, "fill_rst");
      step(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, "fill_rel");
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 1'b1, 32'h99990000 + 32'(i), 4'hF, 1'b0, 1'b0, "fill_push");
      chk("full_tready", 32'(tready), 32'd0);
      chk("full_level", 32'(level), 32'd8);
      step(1'b1, 1'b1, 32'h99990009, 4'hF, 1'b1, 1'b1, "full_pop");
      chk("after_pop_tready", 32'(tready), 32'd1);
      chk("after_pop_level", 32'(level), 32'd7);
      step(1'b1, 1'b1, 32'h99990009, 4'hF, 1'b1, 1'b0, "ninth_push");
      chk("ninth_level", 32'(level), 32'd8);
      for (int i = 0; i < DEPTH - 1; i++)
         step(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, "fill_drain");
      chk("ninth_order", out_data, 32'h99990009);
      step(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, "fill_drain");

      // Streaming pass-through across pointer wrap.
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, $urandom, 4'($urandom_range(1, 15)), 1'(i % 5 == 4), 1'b1, "conc");
         chk("conc_level_le1", 32'(level <= 4'd1), 32'd1);
         chk("conc_tready", 32'(tready), 32'd1);
      end
      step(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, "conc_drain");

      // Reset in the middle of a packet discards everything.
      step(1'b1, 1'b1, 32'hAAAA0001, 4'hF, 1'b0, 1'b0, "mid_push");
      step(1'b1, 1'b1, 32'hAAAA0002, 4'hF, 1'b0, 1'b0, "mid_push");
      step(1'b0, 1'b1, 32'hAAAA0003, 4'hF, 1'b1, 1'b0, "mid_rst");
      chk("mid_level", 32'(level), 32'd0);
      chk("mid_ovalid", 32'(out_valid), 32'd0);
      chk("mid_pkt", 32'(pkt_count), 32'd0);
      step(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, "mid_rel");
      step(1'b1, 1'b1, 32'hBBBB0001, 4'hF, 1'b0, 1'b0, "mid_pkt");
      step(1'b1, 1'b1, 32'hBBBB0002, 4'h3, 1'b0, 1'b0, "mid_pkt");
      step(1'b1, 1'b1, 32'hBBBB0003, 4'h1, 1'b1, 1'b0, "mid_pkt");
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, "mid_drain");
      chk("mid_pkt_after", 32'(pkt_count), 32'd1);

      // Randomized traffic, including null beats, stalls, rare resets and counter wrap.
      for (int i = 0; i < 600; i++) begin
         logic [3:0] k;
         k = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
         step(1'($urandom_range(0, 149) != 0), 1'($urandom), $urandom, k,
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
